quad_tick_counter: RTL
======================

# quad_tick_counter

Parametrised quadrature encoder tick counter for the BLDC controller, successor to the single-channel tick counter in `Main_Module`. It synchronises and glitch-filters the two encoder phases `E_1`/`E_2` and decodes them at 4x resolution into a signed wrapping position. It also produces a per-window signed speed sample, so the speed loop can read velocity directly instead of differencing `Ticks` in software.

## Interface
- `CNT_W`, default 9: width of `POS` and `SPEED` (two's complement).
- `WIN_W`, default 16: width of the window-length input.
- `FILT_LEN`, default 3: consecutive identical samples required to accept a new phase value. Legal range is 1..15.
- `CLK` in, 1 bit: system clock; all logic on the rising edge.
- `RST_1` in, 1 bit: asynchronous, active-low reset.
- `E_1` in, 1 bit: encoder phase A, asynchronous.
- `E_2` in, 1 bit: encoder phase B, asynchronous.
- `CLR` in, 1 bit: synchronous clear of `POS`, the window accumulator and `ERR`.
- `WIN_CYC` in, `WIN_W` bits: speed window length in `CLK` cycles; 0 disables speed sampling.
- `POS` out, `CNT_W` bits: signed position, wraps modulo 2^`CNT_W`.
- `SPEED` out, `CNT_W` bits: signed ticks counted in the last completed window, saturated.
- `SPEED_VLD` out, 1 bit: one-cycle pulse when `SPEED` updates.
- `DIR` out, 1 bit: direction of the last accepted step; 1 = forward.
- `ERR` out, 1 bit: sticky illegal-transition flag.
- `IDX` in, 1 bit: index pulse, asynchronous. Exists only with `ETC_INDEX_EN`.
- `IDX_SEEN` out, 1 bit: sticky "index seen" flag. Exists only with `ETC_INDEX_EN`.

## Operation
- **Synchronisers:** each of `E_1`, `E_2` (and `IDX`) passes through a 2-FF synchroniser.
- **Filter, per phase:**
  - A stability counter loads 1 whenever the synchroniser output differs from the last sample; otherwise it increments, saturating at `FILT_LEN`.
  - The filtered value takes the new level when the counter reaches `FILT_LEN`.
  - Pulses shorter than `FILT_LEN` cycles never reach the decoder.
- **Decoder:** compares the filtered `{A,B}` = `{E_1,E_2}` with its previous value.
  - Forward sequence 00→10→11→01→00 gives +1 and sets `DIR`=1.
  - The reverse sequence gives −1 and sets `DIR`=0.
  - No change gives 0.
  - Both bits changing in one cycle is illegal: no count, `DIR` holds, `ERR` is set.
- **Position:** `POS` += step, wrapping (0x0FF + 1 → 0x100 → −256 for `CNT_W`=9; 0 − 1 → 0x1FF).
- **Window:**
  - A cycle counter runs 0..`WIN_CYC`−1 while the accumulator `ACC` (`CNT_W`+1 bits) sums steps.
  - On the terminal cycle (counter ≥ `WIN_CYC`−1): `SPEED` ← sat(`ACC` + step), `SPEED_VLD`=1, `ACC` ← 0, counter ← 0.
  - Saturation limits are +2^(`CNT_W`−1)−1 and −2^(`CNT_W`−1).
- **`WIN_CYC`=0:** the counter and `ACC` are held at 0, `SPEED_VLD` stays 0, and `SPEED` holds its value.
- **`CLR`:**
  - Clears `POS`, `ACC`, the window counter and `ERR`.
  - Any step in the same cycle is discarded.
  - `SPEED` and `DIR` hold.
  - If `CLR` coincides with a terminal cycle, `SPEED_VLD` is suppressed.
- **Reset:** all filter state, synchronisers and previous-phase registers go to 0. The first accepted phase change after reset is decoded against `{0,0}`.

## Timing
- Reset values: `POS`=0, `SPEED`=0, `SPEED_VLD`=0, `DIR`=1, `ERR`=0, `IDX_SEEN`=0.
- Latency: a clean phase edge first sampled at edge 0 updates `POS` and `DIR` after edge 2+`FILT_LEN` (edge 5 with default parameters).
- `SPEED_VLD` is high for exactly one cycle, in the same cycle `SPEED` takes its new value.
- Period is `WIN_CYC` cycles in steady state.
- Changing `WIN_CYC` mid-window takes effect at once. If the running counter is already ≥ the new `WIN_CYC`−1, the window terminates on the next cycle.
- Reset asserted mid-window forces all outputs to reset values immediately. The first window after release starts at counter 0.

## Configuration
- **`ETC_INDEX_EN` defined:** adds `IDX` and `IDX_SEEN`.
  - `IDX` is synchronised (2-FF) and rising-edge detected.
  - On a detected edge: `POS` ← 0 and `IDX_SEEN` ← 1. The step in that cycle is discarded from `POS` but still added to `ACC`.
  - `CLR` also clears `IDX_SEEN`.
- **`ETC_INDEX_EN` undefined:** neither port exists, and `POS` is reset only by `RST_1`/`CLR`.

## Test plan
- **Forward count:** default params, `WIN_CYC`=0, four full forward cycles of `{E_1,E_2}` with 20 clocks per state → `POS`=16, `DIR`=1, `ERR`=0; each `POS` step lands exactly 5 clocks after the first sampling edge.
- **Reverse and wrap:** from reset, one reverse state step → `POS`=0x1FF, `DIR`=0. Then 257 forward steps → `POS`=0x100.
- **Glitch filter:** 2-cycle pulse on `E_1` → `POS` unchanged. 3-cycle pulse → +1, then −1 when the pulse ends.
- **Illegal transition:** force `{E_1,E_2}` 00→11 with both inputs changing in the same cycle → `ERR`=1, `POS` unchanged; `ERR` stays set until a `CLR` pulse, which clears `ERR` and `POS`.
- **Speed window:** `WIN_CYC`=100, 10 forward steps per window → `SPEED`=10 with `SPEED_VLD` every 100 cycles. Driving 300 steps per window with `WIN_CYC`=2000 → `SPEED`=255 (saturated).
- **Index (only with `ETC_INDEX_EN`):** `POS`=37, then `IDX` rising → `POS`=0 and `IDX_SEEN`=1 after 3 clocks; the next forward step gives `POS`=1.

Source files
------------

// File: rtl/quad_tick_counter.sv
// rtl/quad_tick_counter.sv - 4x quadrature decoder with glitch filter, wrapping position and windowed speed
// Optional index input/flag enabled by defining ETC_INDEX_EN.
module quad_tick_counter #(
  parameter int CNT_W    = 9,
  parameter int WIN_W    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic             CLK,
  input  logic             RST_1,
  input  logic             E_1,
  input  logic             E_2,
  input  logic             CLR,
  input  logic [WIN_W-1:0] WIN_CYC,
`ifdef ETC_INDEX_EN
  input  logic             IDX,
  output logic             IDX_SEEN,
`endif
  output logic [CNT_W-1:0] POS,
  output logic [CNT_W-1:0] SPEED,
  output logic             SPEED_VLD,
  output logic             DIR,
  output logic             ERR
);

  localparam int AW = CNT_W + 1;
  localparam logic [3:0] L_FILT = 4'(FILT_LEN);
  localparam logic signed [CNT_W+1:0] L_SMAX = (CNT_W+2)'((1 << (CNT_W-1)) - 1);
  localparam logic signed [CNT_W+1:0] L_SMIN = (CNT_W+2)'(-(1 << (CNT_W-1)));
  localparam logic signed [CNT_W+1:0] L_AMAX = (CNT_W+2)'((1 << CNT_W) - 1);
  localparam logic signed [CNT_W+1:0] L_AMIN = (CNT_W+2)'(-(1 << CNT_W));

  // Bit 1 carries phase A (E_1), bit 0 phase B (E_2).
  logic [1:0] r_sync1, r_sync2, r_last, r_filt, r_prev;
  logic [3:0] r_fcnt [2];
  logic [3:0] w_fcnt_nxt [2];
  logic [1:0] w_filt_nxt;

  logic [AW-1:0]          r_acc;
  logic [WIN_W-1:0]       r_wcnt;
  logic [1:0]             w_delta;
  logic                   w_fwd, w_rev, w_ill, w_term;
  logic signed [CNT_W+1:0] w_step, w_sum;
  logic [CNT_W-1:0]       w_spd_sat;
  logic [AW-1:0]          w_acc_sat;
  logic                   w_idx_rise;

  // Gray phase to position index so forward is always +1 modulo 4.
  function automatic logic [1:0] g2i(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (r_sync2[i] != r_last[i])
        w_fcnt_nxt[i] = 4'd1;
      else if (r_fcnt[i] >= L_FILT)
        w_fcnt_nxt[i] = L_FILT;
      else
        w_fcnt_nxt[i] = r_fcnt[i] + 4'd1;
      w_filt_nxt[i] = (w_fcnt_nxt[i] == L_FILT) ? r_sync2[i] : r_filt[i];
    end
  end

  always_comb begin
    w_delta = g2i(r_filt) - g2i(r_prev);
    w_fwd   = (w_delta == 2'd1);
    w_rev   = (w_delta == 2'd3);
    w_ill   = (w_delta == 2'd2);
    w_step  = '0;
    if (w_fwd)
      w_step = (CNT_W+2)'(1);
    else if (w_rev)
      w_step = '1;
    w_sum = $signed({r_acc[AW-1], r_acc}) + w_step;
    if (w_sum > L_SMAX)
      w_spd_sat = L_SMAX[CNT_W-1:0];
    else if (w_sum < L_SMIN)
      w_spd_sat = L_SMIN[CNT_W-1:0];
    else
      w_spd_sat = w_sum[CNT_W-1:0];
    // Accumulator also clamps so a very long window cannot wrap through zero.
    if (w_sum > L_AMAX)
      w_acc_sat = L_AMAX[AW-1:0];
    else if (w_sum < L_AMIN)
      w_acc_sat = L_AMIN[AW-1:0];
    else
      w_acc_sat = w_sum[AW-1:0];
    w_term = (WIN_CYC != '0) && (r_wcnt >= WIN_CYC - 1'b1);
  end

`ifdef ETC_INDEX_EN
  logic r_idx_s1, r_idx_s2, r_idx_d;
  assign w_idx_rise = r_idx_s2 & ~r_idx_d;

  always_ff @(posedge CLK or negedge RST_1) begin
    if (!RST_1) begin
      r_idx_s1 <= 1'b0;
      r_idx_s2 <= 1'b0;
      r_idx_d  <= 1'b0;
      IDX_SEEN <= 1'b0;
    end else begin
      r_idx_s1 <= IDX;
      r_idx_s2 <= r_idx_s1;
      r_idx_d  <= r_idx_s2;
      if (CLR)
        IDX_SEEN <= 1'b0;
      else if (w_idx_rise)
        IDX_SEEN <= 1'b1;
    end
  end
`else
  assign w_idx_rise = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_1) begin
    if (!RST_1) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_last    <= '0;
      r_filt    <= '0;
      r_prev    <= '0;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
      r_acc     <= '0;
      r_wcnt    <= '0;
      POS       <= '0;
      SPEED     <= '0;
      SPEED_VLD <= 1'b0;
      DIR       <= 1'b1;
      ERR       <= 1'b0;
    end else begin
      r_sync1   <= {E_1, E_2};
      r_sync2   <= r_sync1;
      r_last    <= r_sync2;
      r_filt    <= w_filt_nxt;
      r_prev    <= r_filt;
      r_fcnt[0] <= w_fcnt_nxt[0];
      r_fcnt[1] <= w_fcnt_nxt[1];
      SPEED_VLD <= 1'b0;

      if (CLR || w_idx_rise)
        POS <= '0;
      else
        POS <= POS + w_step[CNT_W-1:0];

      if (CLR)
        ERR <= 1'b0;
      else if (w_ill)
        ERR <= 1'b1;

      if (!CLR && w_fwd)
        DIR <= 1'b1;
      else if (!CLR && w_rev)
        DIR <= 1'b0;

      if (WIN_CYC == '0 || CLR) begin
        r_wcnt <= '0;
        r_acc  <= '0;
      end else if (w_term) begin
        SPEED     <= w_spd_sat;
        SPEED_VLD <= 1'b1;
        r_wcnt    <= '0;
        r_acc     <= '0;
      end else begin
        r_wcnt <= r_wcnt + 1'b1;
        r_acc  <= w_acc_sat;
      end
    end
  end

endmodule
